// File: rtl/pwm_multichannel.sv
// pwm_multichannel: parametrised multi-channel PWM generator.
// Provides a programmable period and a clock prescaler. Per-channel duty
// registers are loaded through a byte-wide register-write port.
// Optional feature macro: PWM_SHADOW_EN. When it is defined, writes land in
// pending registers. Those copy into the active set atomically on each period
// wrap, which keeps `out` glitch-free.
// Register map: 0..NUM_CH-1 = duty[i], NUM_CH = period, NUM_CH+1 = prescaler.
module pwm_multichannel #(
  parameter int NUM_CH = 16,
  parameter int CNT_W  = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [CNT_W-1:0]  wr_data,
  input  logic [NUM_CH-1:0] en_out,
  input  logic [NUM_CH-1:0] en_pwm,
  output logic [NUM_CH-1:0] out,
  output logic              period_start
);

  localparam logic [ADDR_W-1:0] ADDR_PERIOD = ADDR_W'(NUM_CH);
  localparam logic [ADDR_W-1:0] ADDR_PRESC  = ADDR_W'(NUM_CH + 1);

  // Write decode. Addresses beyond the prescaler register are dropped.
  logic wr_ok;
  logic wr_period;
  logic wr_presc;
  assign wr_ok     = wr_en && (wr_addr <= ADDR_PRESC);
  assign wr_period = wr_ok && (wr_addr == ADDR_PERIOD);
  assign wr_presc  = wr_ok && (wr_addr == ADDR_PRESC);

  logic [CNT_W-1:0]  period_reg;
  logic [CNT_W-1:0]  presc_reg;
  logic [CNT_W-1:0]  pre_cnt_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              tick;
  logic              wrap;
  logic              wrap_d_reg;
  logic [NUM_CH-1:0] raw;
  logic [NUM_CH-1:0] out_reg;
  logic              period_start_reg;

  // A tick closes each prescaler cycle. A tick with cnt at or past the period
  // wraps the counter; >= also recovers when the period is lowered below cnt.
  assign tick = (pre_cnt_reg == presc_reg);
  assign wrap = tick && (cnt_reg >= period_reg);

`ifdef PWM_SHADOW_EN
  logic [CNT_W-1:0] period_pend_reg;
  logic [CNT_W-1:0] presc_pend_reg;
  logic [CNT_W-1:0] period_next;
  logic [CNT_W-1:0] presc_next;

  // Pending values, with a write in this cycle bypassed in so that a write
  // coincident with the wrap still reaches the active set.
  always_comb begin
    period_next = period_pend_reg;
    presc_next  = presc_pend_reg;
    if (wr_period) period_next = wr_data;
    if (wr_presc)  presc_next  = wr_data;
  end

  // Pending registers track every write; the active set loads them only on a wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_pend_reg <= '1;
      presc_pend_reg  <= '0;
      period_reg      <= '1;
      presc_reg       <= '0;
    end else begin
      period_pend_reg <= period_next;
      presc_pend_reg  <= presc_next;
      if (wrap) begin
        period_reg <= period_next;
        presc_reg  <= presc_next;
      end
    end
  end
`else
  // Period and prescaler take writes directly. A mid-period change may glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_reg <= '1;
      presc_reg  <= '0;
    end else begin
      if (wr_period) period_reg <= wr_data;
      if (wr_presc)  presc_reg  <= wr_data;
    end
  end
`endif

  // Per-channel duty storage and compare.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : gen_ch
    logic [CNT_W-1:0] duty_reg;
    logic             duty_wr;

    assign duty_wr = wr_ok && (wr_addr == ADDR_W'(gi));

`ifdef PWM_SHADOW_EN
    logic [CNT_W-1:0] duty_pend_reg;
    logic [CNT_W-1:0] duty_next;

    assign duty_next = duty_wr ? wr_data : duty_pend_reg;

    // Pending duty follows writes; the active duty loads it at the wrap.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        duty_pend_reg <= '0;
        duty_reg      <= '0;
      end else begin
        duty_pend_reg <= duty_next;
        if (wrap) duty_reg <= duty_next;
      end
    end
`else
    // Duty takes writes directly and is used by the compare on the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        duty_reg <= '0;
      end else if (duty_wr) begin
        duty_reg <= wr_data;
      end
    end
`endif

    // All-ones duty is pinned high, so it stays high even when cnt reaches all-ones.
    assign raw[gi] = (cnt_reg < duty_reg) || (duty_reg == '1);
  end

  // Prescaler and period counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_reg <= '0;
      cnt_reg     <= '0;
    end else begin
      pre_cnt_reg <= tick ? '0 : pre_cnt_reg + CNT_W'(1);
      if (tick) begin
        cnt_reg <= wrap ? '0 : cnt_reg + CNT_W'(1);
      end
    end
  end

  // Register the outputs. period_start lines up with the first out cycle that shows cnt = 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg          <= '0;
      wrap_d_reg       <= 1'b0;
      period_start_reg <= 1'b0;
    end else begin
      out_reg          <= en_out & (~en_pwm | raw);
      wrap_d_reg       <= wrap;
      period_start_reg <= wrap_d_reg;
    end
  end

  assign out          = out_reg;
  assign period_start = period_start_reg;

endmodule

// File: tb/tb_pwm_multichannel.sv
// tb_pwm_multichannel: directed bench for pwm_multichannel.
// A cycle-level model in the bench predicts out/period_start and is checked
// on every falling edge. Hand-computed literals pin the key timings.
// Inputs change 1 time unit after the rising edge.
module tb_pwm_multichannel;
  localparam int NUM_CH = 16;
  localparam int CNT_W  = 8;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [CNT_W-1:0]  wr_data = '0;
  logic [NUM_CH-1:0] en_out = '1;
  logic [NUM_CH-1:0] en_pwm = '1;
  logic [NUM_CH-1:0] out;
  logic              period_start;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  pwm_multichannel #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .en_out(en_out), .en_pwm(en_pwm), .out(out), .period_start(period_start)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_duty[NUM_CH];
  int p_duty[NUM_CH];
  int m_period, m_presc, p_period, p_presc;
  int m_pre, m_cnt;
  bit m_wrap_d;
  logic [NUM_CH-1:0] m_out;
  logic m_ps;

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_duty[i] = 0;
      p_duty[i] = 0;
    end
    m_period = 255; p_period = 255;
    m_presc = 0;    p_presc = 0;
    m_pre = 0; m_cnt = 0; m_wrap_d = 0;
    m_out = '0; m_ps = 1'b0;
  endtask

  task automatic model_step();
    bit tick, wrap, r;
    logic [NUM_CH-1:0] nout;
    int a;
    tick = (m_pre == m_presc);
    wrap = tick && (m_cnt >= m_period);
    for (int i = 0; i < NUM_CH; i++) begin
      r = (m_cnt < m_duty[i]) || (m_duty[i] == 255);
      nout[i] = en_out[i] && (!en_pwm[i] || r);
    end
    m_out = nout;
    m_ps = m_wrap_d;
    m_wrap_d = wrap;
    m_pre = tick ? 0 : (m_pre + 1) % 256;
    if (tick) m_cnt = wrap ? 0 : m_cnt + 1;
    a = int'(wr_addr);
    if (wr_en && a <= NUM_CH + 1) begin
`ifdef PWM_SHADOW_EN
      if (a < NUM_CH) p_duty[a] = int'(wr_data);
      else if (a == NUM_CH) p_period = int'(wr_data);
      else p_presc = int'(wr_data);
`else
      if (a < NUM_CH) m_duty[a] = int'(wr_data);
      else if (a == NUM_CH) m_period = int'(wr_data);
      else m_presc = int'(wr_data);
`endif
    end
`ifdef PWM_SHADOW_EN
    if (wrap) begin
      for (int i = 0; i < NUM_CH; i++) m_duty[i] = p_duty[i];
      m_period = p_period;
      m_presc = p_presc;
    end
`endif
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=0x%0h required=0x%0h", name, $time, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("cyc_out", 32'(out), 32'(m_out));
        check("cyc_ps", 32'(period_start), 32'(m_ps));
      end
    end
  end

  // Issue a one-cycle write strobe. Call this 1 time unit after a rising edge.
  task automatic write_now(input int a, input int d);
    wr_en = 1'b1;
    wr_addr = ADDR_W'(a);
    wr_data = CNT_W'(d);
    $display("write addr=%0d data=%0d t=%0t", a, d, $time);
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // Count falling edges up to and including the next period_start pulse.
  task automatic wait_ps(input int limit, output int n);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (period_start === 1'b1) break;
      if (n >= limit) begin
        checks++;
        failures++;
        $display("FAIL wait_ps timeout actual=%0d required<%0d", n, limit);
        break;
      end
    end
  endtask

  int n, hi0, hi1, hi2, hi3, ps_cnt;

  initial begin
    chk_en = 1'b1;
    // Reset held with every channel enabled.
    repeat (5) begin
      @(negedge clk);
      check("rst_out", 32'(out), 32'd0);
      check("rst_ps", 32'(period_start), 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_ps(400, n);
    check("first_ps_delay", n, 258);
    $display("reset release: first period_start after %0d cycles", n);

    // Basic duty: period 9, duty[3] = 4.
    @(posedge clk); #1;
    write_now(NUM_CH, 9);
    write_now(3, 4);
    wait_ps(400, n);
    wait_ps(40, n);
    check("basic_period", n, 10);
    hi3 = 0; ps_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      hi3 += int'(out[3]);
      ps_cnt += int'(period_start);
    end
    check("basic_hi3", hi3, 8);
    check("basic_ps_cnt", ps_cnt, 2);

    // Duty update mid-period: duty[0] goes from 2 to 7 while cnt = 4.
    @(posedge clk); #1;
    write_now(0, 2);
    wait_ps(40, n);
    wait_ps(40, n);
    repeat (3) @(posedge clk);
    #1;
    write_now(0, 7);
    @(negedge clk);
    check("upd_cnt4", 32'(out[0]), 32'd0);
    @(negedge clk);
`ifdef PWM_SHADOW_EN
    check("upd_cnt5", 32'(out[0]), 32'd0);
`else
    check("upd_cnt5", 32'(out[0]), 32'd1);
`endif
    wait_ps(40, n);
    check("upd_next_ps", n, 5);
    hi0 = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      hi0 += int'(out[0]);
    end
    check("upd_next_hi0", hi0, 7);

    // Boundary: lower the period to 3 while cnt = 6.
    wait_ps(40, n);
    repeat (5) @(posedge clk);
    #1;
    write_now(NUM_CH, 3);
    wait_ps(40, n);
`ifdef PWM_SHADOW_EN
    check("bnd_wrap", n, 5);
`else
    check("bnd_wrap", n, 3);
`endif
    wait_ps(40, n);
    check("bnd_period4", n, 4);

    // Out-of-range writes must change nothing.
    @(posedge clk); #1;
    write_now(NUM_CH + 2, 0);
    write_now(31, 0);
    wait_ps(40, n);
    wait_ps(40, n);
    check("oor_period4", n, 4);

    // Prescaler 1, period 3, duty extremes.
    @(posedge clk); #1;
    write_now(NUM_CH + 1, 1);
    write_now(NUM_CH, 3);
    write_now(0, 0);
    write_now(1, 2);
    write_now(2, 255);
    wait_ps(40, n);
    wait_ps(40, n);
    check("presc_period8", n, 8);
    hi0 = 0; hi1 = 0; hi2 = 0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      hi0 += int'(out[0]);
      hi1 += int'(out[1]);
      hi2 += int'(out[2]);
    end
    check("presc_hi0", hi0, 0);
    check("presc_hi1", hi1, 4);
    check("presc_hi2", hi2, 8);

    // Static-high mode and output disable on channel 5 (duty[5] = 0).
    @(posedge clk); #1;
    en_pwm[5] = 1'b0;
    @(negedge clk);
    check("static_before", 32'(out[5]), 32'd0);
    @(negedge clk);
    check("static_high", 32'(out[5]), 32'd1);
    @(posedge clk); #1;
    en_out[5] = 1'b0;
    @(negedge clk);
    check("disable_before", 32'(out[5]), 32'd1);
    @(negedge clk);
    check("disable_low", 32'(out[5]), 32'd0);

    // Asynchronous reset mid-period clears the outputs at once.
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out", 32'(out), 32'd0);
    check("midrst_ps", 32'(period_start), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
